dec_fsm: RTL and testbench
==========================

# dec_fsm

Sequencing controller for the decoder side of the coder stack. It accepts the encoded block stream produced by the encoder path: K data symbols followed by TAIL_LEN tail symbols. It writes data symbols into the decoder input buffer and captures tail symbols. It then drives ITER decoder iterations through a start/done handshake and reads the decoded block out to the downstream consumer, flagging the last beat.

## Interface
Parameters:
- LEN_W, 13, width of block length, address and data counters
- TAIL_LEN, 4, number of tail symbols following the data symbols (≥1)
- ITER, 8, number of decoder iterations per block (≥1)

Ports:
- clock  in  1  single clock, all state on rising edge
- aclr  in  1  asynchronous active-high reset
- in_valid  in  1  encoded symbol present on the input
- block_len  in  LEN_W  block length K, sampled when the first symbol is accepted in IDLE
- iter_done  in  1  one-cycle pulse from the decoder core at the end of an iteration
- out_ready  in  1  downstream may take one decoded bit
- in_ready  out  1  symbol accepted when in_valid & in_ready
- wr_en  out  1  write data symbol to input buffer
- wr_addr  out  LEN_W  input buffer write address
- tail_wen  out  1  capture tail symbol
- tail_idx  out  3  tail symbol index 0..TAIL_LEN-1
- dec_start  out  1  one-cycle pulse that starts one decoder iteration
- rd_en  out  1  read decoded bit from output buffer
- rd_addr  out  LEN_W  output buffer read address
- out_valid  out  1  decoded bit valid (registered)
- out_last  out  1  qualifies the final decoded bit (registered)
- busy  out  1  high in every state except IDLE
- state  out  3  current state encoding

## Operation
- States: IDLE=0, LOAD=1, TAIL=2, START=3, WAIT_ITER=4, OUTPUT=5, DONE=6. Encoding 7 is unreachable and recovers to IDLE on the next clock.
- Klat = block_len sampled on the first accept. block_len = 0 is treated as 1.
- in_ready = state is IDLE, LOAD or TAIL. It is high in every other state's complement only; it is low in all other states.
- wr_en = in_valid & (state is IDLE or LOAD), combinational. wr_addr = data counter.
- IDLE: on accept, latch Klat and write address 0. If Klat = 1, go to TAIL; otherwise go to LOAD with data counter = 1.
- LOAD: each accept writes at data counter and increments it. An accept at counter Klat-1 goes to TAIL. in_valid gaps stall the state with no writes.
- TAIL: tail_wen = in_valid, tail_idx = tail counter. An accept at index TAIL_LEN-1 goes to START.
- START: dec_start = 1 for exactly this cycle. Always goes to WAIT_ITER.
- WAIT_ITER: waits for iter_done. If the iteration counter = ITER-1, go to OUTPUT and clear the iteration counter. Otherwise increment the iteration counter and go to START.
- iter_done is ignored in every state other than WAIT_ITER.
- OUTPUT: rd_en = out_ready, rd_addr = read counter. Each rd_en increments the read counter. rd_en at address Klat-1 goes to DONE.
- DONE: lasts one cycle, then goes to IDLE. All counters clear on entry to IDLE.
- out_valid is rd_en registered, matching the 1-cycle buffer read latency. out_last is registered (rd_en & rd_addr = Klat-1).
- out_ready throttles reads only. Downstream must take every out_valid beat.

## Timing
- Reset (asynchronous): state = IDLE, all counters = 0, out_valid = 0, out_last = 0. The combinational outputs follow from IDLE: in_ready = 1, busy = 0, dec_start = 0, rd_en = 0, tail_wen = 0. wr_en follows in_valid in IDLE.
- aclr asserted mid-block, in any state, aborts the block. No further dec_start, rd_en or out_valid is issued until a new block is loaded.
- Input-to-decode: the last tail accept occurs in cycle t. dec_start pulses in cycle t+1.
- Iteration spacing: iter_done in cycle t gives the next dec_start in cycle t+1.
- Output: a read issued in cycle t has out_valid in cycle t+1. The final beat's out_valid and out_last appear in the DONE cycle.
- Back-to-back blocks: IDLE is reached one cycle after DONE, and in_ready is high again in that cycle.
- The minimum cycle count for a block is Klat + TAIL_LEN + 2·ITER + Klat + 1, with no stalls and iter_done arriving immediately.

## Test plan
- K=4, TAIL_LEN=4, ITER=2, in_valid continuous, iter_done one cycle after each dec_start, out_ready=1:
  - wr_addr 0..3 in 4 cycles
  - tail_wen in 4 cycles with tail_idx 0..3
  - 2 dec_start pulses
  - rd_addr 0..3, then out_valid for 4 beats with out_last on beat 4
  - back in IDLE
- Same block with in_valid pattern 1,0,0,1,… : writes only on accept cycles, addresses contiguous 0..3, no state advance during gaps.
- OUTPUT with out_ready = 1,0,1,1,0,1: rd_addr advances only when out_ready is high. out_valid mirrors rd_en delayed one cycle. out_last accompanies address 3.
- aclr pulsed during WAIT_ITER of the second iteration: state goes to 0 immediately, out_valid stays 0, no dec_start follows. A new K=2 block then completes normally.
- block_len=0: treated as K=1. One data write at address 0, then TAIL, and a single output beat with out_valid=out_last=1.
- iter_done pulsed in LOAD, TAIL and START: ignored. The iteration count still requires exactly ITER iter_done pulses observed in WAIT_ITER.

Source files
------------

// File: rtl/dec_if.sv
// dec_if: decoder sequencer handshake and buffer-control bundle
interface dec_if #(parameter int LEN_W = 13);
  logic             in_valid;
  logic [LEN_W-1:0] block_len;
  logic             iter_done;
  logic             out_ready;
  logic             in_ready;
  logic             wr_en;
  logic [LEN_W-1:0] wr_addr;
  logic             tail_wen;
  logic [2:0]       tail_idx;
  logic             dec_start;
  logic             rd_en;
  logic [LEN_W-1:0] rd_addr;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic [2:0]       state;
  modport slave (
    input  in_valid, block_len, iter_done, out_ready,
    output in_ready, wr_en, wr_addr, tail_wen, tail_idx, dec_start,
           rd_en, rd_addr, out_valid, out_last, busy, state
  );
  modport master (
    output in_valid, block_len, iter_done, out_ready,
    input  in_ready, wr_en, wr_addr, tail_wen, tail_idx, dec_start,
           rd_en, rd_addr, out_valid, out_last, busy, state
  );
endinterface

// File: rtl/dec_fsm.sv
// dec_fsm: loads a block plus tail, runs ITER decoder passes, streams the decoded block out
module dec_fsm #(
  parameter int LEN_W    = 13,
  parameter int TAIL_LEN = 4,
  parameter int ITER     = 8
) (
  input logic  clock,
  input logic  aclr,
  dec_if.slave bus
);
  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, TAIL = 3'd2, START = 3'd3,
    WAIT_ITER = 3'd4, OUTPUT = 3'd5, DONE = 3'd6
  } state_t;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] klat_q, klat_d, dcnt_q, dcnt_d, rcnt_q, rcnt_d;
  logic [LEN_W-1:0] klat_m1, blk_eff;
  logic [2:0]       tcnt_q, tcnt_d;
  logic [IW-1:0]    icnt_q, icnt_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  // a zero length block is handled as a single symbol
  assign blk_eff = (bus.block_len == '0) ? LEN_W'(1) : bus.block_len;
  assign klat_m1 = klat_q - LEN_W'(1);
  assign bus.in_ready  = (state_q == IDLE) || (state_q == LOAD) || (state_q == TAIL);
  assign bus.wr_en     = bus.in_valid && ((state_q == IDLE) || (state_q == LOAD));
  assign bus.wr_addr   = dcnt_q;
  assign bus.tail_wen  = bus.in_valid && (state_q == TAIL);
  assign bus.tail_idx  = tcnt_q;
  assign bus.dec_start = (state_q == START);
  assign bus.rd_en     = bus.out_ready && (state_q == OUTPUT);
  assign bus.rd_addr   = rcnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state     = state_q;
  always_comb begin
    state_d     = state_q;
    klat_d      = klat_q;
    dcnt_d      = dcnt_q;
    tcnt_d      = tcnt_q;
    icnt_d      = icnt_q;
    rcnt_d      = rcnt_q;
    out_valid_d = bus.rd_en;
    out_last_d  = bus.rd_en && (rcnt_q == klat_m1);
    case (state_q)
      IDLE: if (bus.in_valid) begin
        klat_d  = blk_eff;
        state_d = (blk_eff == LEN_W'(1)) ? TAIL : LOAD;
        dcnt_d  = (blk_eff == LEN_W'(1)) ? dcnt_q : LEN_W'(1);
      end
      LOAD: if (bus.in_valid) begin
        dcnt_d  = dcnt_q + LEN_W'(1);
        state_d = (dcnt_q == klat_m1) ? TAIL : LOAD;
      end
      TAIL: if (bus.in_valid) begin
        tcnt_d  = tcnt_q + 3'd1;
        state_d = (tcnt_q == 3'(TAIL_LEN - 1)) ? START : TAIL;
      end
      START: state_d = WAIT_ITER;
      WAIT_ITER: if (bus.iter_done) begin
        state_d = (icnt_q == IW'(ITER - 1)) ? OUTPUT : START;
        icnt_d  = (icnt_q == IW'(ITER - 1)) ? '0 : icnt_q + IW'(1);
      end
      OUTPUT: if (bus.out_ready) begin
        rcnt_d  = rcnt_q + LEN_W'(1);
        state_d = (rcnt_q == klat_m1) ? DONE : OUTPUT;
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
        tcnt_d  = '0;
        icnt_d  = '0;
        rcnt_d  = '0;
      end
    endcase
  end
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q     <= IDLE;
      klat_q      <= '0;
      dcnt_q      <= '0;
      tcnt_q      <= '0;
      icnt_q      <= '0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      klat_q      <= klat_d;
      dcnt_q      <= dcnt_d;
      tcnt_q      <= tcnt_d;
      icnt_q      <= icnt_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule

// File: tb/tb_dec_fsm.sv
// tb_dec_fsm: directed checks of load, tail, iteration, readout, reset abort and edge cases
module tb_dec_fsm;
  logic clk = 1'b0;
  logic aclr = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  dec_if #(.LEN_W(13)) d();
  dec_fsm #(.LEN_W(13), .TAIL_LEN(4), .ITER(2)) dut (.clock(clk), .aclr(aclr), .bus(d.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load_blk(input int k, input logic [3:0] pat, input logic noise);
    int kk = (k == 0) ? 1 : k;
    int a = 0;
    int c = 0;
    logic v;
    d.block_len = 13'(k);
    d.iter_done = noise;
    while (a < kk + 4 && c < 100) begin
      v = pat[c % 4];
      d.in_valid = v;
      #1;
      chk("in_ready", d.in_ready, 1);
      if (a < kk) begin
        chk("ld_state", d.state, (a == 0) ? 0 : 1);
        chk("wr_en", d.wr_en, v);
        chk("wr_addr", d.wr_addr, a);
        chk("tail_wen_ld", d.tail_wen, 0);
      end else begin
        chk("tl_state", d.state, 2);
        chk("tail_wen", d.tail_wen, v);
        chk("tail_idx", d.tail_idx, a - kk);
        chk("wr_en_tail", d.wr_en, 0);
      end
      tick;
      if (v) a++;
      c++;
    end
    chk("load_bound", c < 100, 1);
    d.in_valid = 1'b0;
    d.iter_done = 1'b0;
  endtask
  task automatic iters(input int n, input logic noise);
    for (int i = 0; i < n; i++) begin
      d.iter_done = noise;
      #1;
      chk("st_state", d.state, 3);
      chk("dec_start", d.dec_start, 1);
      chk("in_ready_st", d.in_ready, 0);
      tick;
      d.iter_done = 1'b1;
      #1;
      chk("wt_state", d.state, 4);
      chk("dec_start_wt", d.dec_start, 0);
      tick;
      d.iter_done = 1'b0;
    end
  endtask
  task automatic unload(input int kk, input logic [7:0] rp, input int np);
    int r = 0;
    int c = 0;
    logic v;
    logic pv = 1'b0;
    logic pl = 1'b0;
    while (r < kk && c < 100) begin
      v = rp[c % np];
      d.out_ready = v;
      #1;
      chk("out_state", d.state, 5);
      chk("rd_en", d.rd_en, v);
      chk("rd_addr", d.rd_addr, r);
      chk("out_valid", d.out_valid, pv);
      chk("out_last", d.out_last, pl);
      chk("in_ready_out", d.in_ready, 0);
      pv = v;
      pl = v && (r == kk - 1);
      tick;
      if (v) r++;
      c++;
    end
    chk("out_bound", c < 100, 1);
    d.out_ready = 1'b0;
    #1;
    chk("done_state", d.state, 6);
    chk("done_valid", d.out_valid, 1);
    chk("done_last", d.out_last, 1);
    chk("done_busy", d.busy, 1);
    tick;
    chk("idle_state", d.state, 0);
    chk("idle_ready", d.in_ready, 1);
    chk("idle_busy", d.busy, 0);
    chk("idle_valid", d.out_valid, 0);
  endtask
  initial begin
    d.in_valid = 1'b0;
    d.block_len = '0;
    d.iter_done = 1'b0;
    d.out_ready = 1'b0;
    #1;
    chk("rst_state", d.state, 0);
    chk("rst_ready", d.in_ready, 1);
    chk("rst_busy", d.busy, 0);
    chk("rst_start", d.dec_start, 0);
    chk("rst_rd_en", d.rd_en, 0);
    chk("rst_tail_wen", d.tail_wen, 0);
    chk("rst_valid", d.out_valid, 0);
    chk("rst_last", d.out_last, 0);
    d.in_valid = 1'b1;
    #1;
    chk("rst_wr_en", d.wr_en, 1);
    d.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aclr = 1'b0;
    load_blk(4, 4'b1111, 1'b0);
    iters(2, 1'b0);
    unload(4, 8'hFF, 1);
    load_blk(4, 4'b1001, 1'b0);
    iters(2, 1'b0);
    unload(4, 8'b0010_1101, 6);
    load_blk(4, 4'b1111, 1'b0);
    iters(1, 1'b0);
    #1;
    chk("ab_state3", d.state, 3);
    chk("ab_start", d.dec_start, 1);
    tick;
    chk("ab_state4", d.state, 4);
    aclr = 1'b1;
    #1;
    chk("ab_state0", d.state, 0);
    chk("ab_valid", d.out_valid, 0);
    chk("ab_busy", d.busy, 0);
    tick;
    aclr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d.iter_done = (i == 0);
      #1;
      chk("ab_idle", d.state, 0);
      chk("ab_no_start", d.dec_start, 0);
      chk("ab_no_rd", d.rd_en, 0);
      chk("ab_no_valid", d.out_valid, 0);
      tick;
    end
    d.iter_done = 1'b0;
    load_blk(2, 4'b1111, 1'b0);
    iters(2, 1'b0);
    unload(2, 8'hFF, 1);
    load_blk(0, 4'b1111, 1'b0);
    iters(2, 1'b0);
    unload(1, 8'hFF, 1);
    load_blk(3, 4'b1111, 1'b1);
    iters(2, 1'b1);
    unload(3, 8'hFF, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
